bin_to_bcd_seq: RTL



---
 rtl/bin_to_bcd_seq.sv | 97 +++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the seven-segment decoders.
// Values that do not fit in DIGITS decimal digits come out as blank (4'hF) nibbles with ovf set.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SW    = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Compared at 64 bits so the check is simply false when 2^BIN_W <= 10^DIGITS
  localparam logic [63:0] LIMIT = 64'(pow10(DIGITS));

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nx;
  logic [SW-1:0]      scr, adj, shifted;
  logic [CNT_W-1:0]   cnt;
  logic               rng;
  logic               last;
  logic [63:0]        bin_ext;

  assign bin_ext = {{(64-BIN_W){1'b0}}, bin};
  assign last    = (cnt == CNT_W'(1));

  // Per-digit add-3 correction; each nibble is adjusted independently, so no carries cross digits
  assign adj[BIN_W-1:0] = scr[BIN_W-1:0];
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic [3:0] nib;
    assign nib = scr[BIN_W+4*k +: 4];
    assign adj[BIN_W+4*k +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end
  assign shifted = {adj[SW-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scr  <= '0;
      cnt  <= '0;
      rng  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      bcd  <= '0;
      ovf  <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_nx == SHIFT);
      case (state)
        IDLE: if (start) begin
          scr <= {{BCD_W{1'b0}}, bin};
          rng <= (bin_ext >= LIMIT);
          cnt <= CNT_W'(BIN_W);
        end
        SHIFT: begin
          scr <= shifted;
          cnt <= cnt - 1'b1;
          if (last) begin
            bcd  <= rng ? {BCD_W{1'b1}} : shifted[SW-1:BIN_W];
            ovf  <= rng;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
